// File: rtl/period_meter_pkg.sv
// Shared types for the period meter.
// Holds the FSM state encoding used by the top level.
package period_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS_HI,
    S_MEAS_LO,
    S_DONE
  } state_t;

endpackage

// File: rtl/period_meter_sig_sync.sv
// sig_sync_edge: synchronizer chain plus edge-detect flop.
// Ports: clk, rst_n, sig_in (async) -> rise/fall one-cycle strobes.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;
  assign fall = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures high time and period of sig_in in clk cycles.
// Ports: clk, rst_n, en, start, cont, sig_in -> busy, valid, high_cnt, period, div_est, symmetric, timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          cont,
  input  logic          sig_in,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period,
  output logic [CW-2:0] div_est,
  output logic          symmetric,
  output logic          timeout
);

  localparam logic [CW-1:0] CMAX = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_cap;
  logic          rise;
  logic          fall;
  logic [CW-2:0] div_next;
  logic          sym_next;

  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Derived results are computed from the live counter, which equals
  // the period capture on the closing-rise cycle.
  assign div_next = (cnt < CW'(2)) ? '0 : cnt[CW-1:1] - 1'b1;
  assign sym_next = ({hi_cap, 1'b0} == {1'b0, cnt});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi_cap    <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      high_cnt  <= '0;
      period    <= '0;
      div_est   <= '0;
      symmetric <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_ARM;
              busy    <= 1'b1;
              timeout <= 1'b0;
              cnt     <= CW'(1);
            end
          end
          S_ARM: begin
            if (cnt == CMAX) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else if (rise) begin
              state <= S_MEAS_HI;
              cnt   <= CW'(1);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_MEAS_HI: begin
            if (cnt == CMAX) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else if (fall) begin
              hi_cap <= cnt;
              cnt    <= cnt + 1'b1;
              state  <= S_MEAS_LO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_MEAS_LO: begin
            if (cnt == CMAX) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else if (rise) begin
              // Results are loaded here so they appear together with
              // valid during the DONE cycle.
              state     <= S_DONE;
              valid     <= 1'b1;
              high_cnt  <= hi_cap;
              period    <= cnt;
              div_est   <= div_next;
              symmetric <= sym_next;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (cont) begin
              // Closing rise counted as 1, this cycle as 2.
              state <= S_MEAS_HI;
              cnt   <= CW'(2);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter.
// Uses a CW=16 instance for measurements and a CW=4 instance for saturation.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        sig_in;
  logic        busy, valid, symmetric, timeout;
  logic [15:0] high_cnt, period;
  logic [14:0] div_est;

  logic        start4 = 1'b0;
  logic        sig4 = 1'b0;
  logic        busy4, valid4, sym4, to4;
  logic [3:0]  high4, per4;
  logic [2:0]  div4;

  int n_assert = 0;
  int n_fail = 0;

  // Synchronous pattern generator (changes on negedge) and async source.
  logic gen_on = 1'b0;
  logic gen_level = 1'b0;
  logic gen_sig = 1'b0;
  int   hi_len = 4;
  int   lo_len = 4;
  int   pc = 0;
  logic use_async = 1'b0;
  logic async_on = 1'b0;
  logic async_sig = 1'b0;

  assign sig_in = use_async ? async_sig : gen_sig;

  always #5 clk = ~clk;

  period_meter #(.CW(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont),
    .sig_in(sig_in), .busy(busy), .valid(valid), .high_cnt(high_cnt),
    .period(period), .div_est(div_est), .symmetric(symmetric),
    .timeout(timeout)
  );

  period_meter #(.CW(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start4), .cont(1'b0),
    .sig_in(sig4), .busy(busy4), .valid(valid4), .high_cnt(high4),
    .period(per4), .div_est(div4), .symmetric(sym4), .timeout(to4)
  );

  always @(negedge clk) begin
    if (!gen_on) begin
      gen_sig = gen_level;
      pc = 0;
    end else begin
      pc = pc + 1;
      if (gen_sig && pc >= hi_len) begin
        gen_sig = 1'b0;
        pc = 0;
      end else if (!gen_sig && pc >= lo_len) begin
        gen_sig = 1'b1;
        pc = 0;
      end
    end
  end

  // Edges every 49..51 ns with a 3 ns phase offset: unrelated to clk.
  initial begin
    #3;
    forever begin
      if (async_on) #(49 + $urandom_range(0, 2)) async_sig = ~async_sig;
      else #7;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
  endtask

  initial begin
    bit ok;
    int nv;
    int gap;
    int nb;

    // Reset state
    cyc(3);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_period", period, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: toggle divider N=3 -> toggles every 4 cycles
    hi_len = 4; lo_len = 4; gen_on = 1'b1;
    cyc(5);
    pulse_start();
    check("t1_busy", busy, 1);
    wait_valid(60, ok);
    check("t1_valid_seen", ok, 1);
    check("t1_high", high_cnt, 4);
    check("t1_period", period, 8);
    check("t1_div", div_est, 3);
    check("t1_sym", symmetric, 1);
    @(negedge clk);
    check("t1_valid_once", valid, 0);
    check("t1_idle", busy, 0);
    count_valid(30, nv);
    check("t1_no_more_valid", nv, 0);

    // 2: cascade of settings 1 and 2: /4 then toggle every 3 -> 12 clk
    hi_len = 12; lo_len = 12;
    cyc(3);
    pulse_start();
    wait_valid(150, ok);
    check("t2_valid_seen", ok, 1);
    check("t2_high", high_cnt, 12);
    check("t2_period", period, 24);
    check("t2_div", div_est, 11);
    check("t2_sym", symmetric, 1);

    // 3: high 3 / low 7, continuous
    hi_len = 3; lo_len = 7; cont = 1'b1;
    cyc(3);
    pulse_start();
    wait_valid(80, ok);
    check("t3_valid_seen", ok, 1);
    check("t3_high", high_cnt, 3);
    check("t3_period", period, 10);
    check("t3_div", div_est, 4);
    check("t3_sym", symmetric, 0);
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_second_valid", ok, 1);
    check("t3_gap", gap, 10);
    check("t3_period2", period, 10);
    check("t3_busy_cont", busy, 1);

    // 5a: EN low in MEAS_LO -> outputs hold, no valid
    cyc(5);
    en = 1'b0;
    count_valid(25, nv);
    check("t5e_no_valid", nv, 0);
    check("t5e_busy", busy, 0);
    check("t5e_high_hold", high_cnt, 3);
    check("t5e_period_hold", period, 10);
    check("t5e_div_hold", div_est, 4);
    en = 1'b1;

    // START together with EN low is ignored
    en = 1'b0;
    pulse_start();
    check("en_wins", busy, 0);
    en = 1'b1;

    // 5b: reset in MEAS_LO -> outputs 0, no valid
    pulse_start();
    wait_valid(40, ok);
    check("t5r_valid_seen", ok, 1);
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("t5r_high0", high_cnt, 0);
    check("t5r_period0", period, 0);
    check("t5r_busy0", busy, 0);
    check("t5r_valid0", valid, 0);
    cyc(3);
    rst_n = 1'b1;
    cont = 1'b0;
    count_valid(25, nv);
    check("t5r_no_valid", nv, 0);
    check("t5r_div0", div_est, 0);

    // 4: CW=4, stuck-low input -> timeout after 15 ARM cycles
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    nb = 0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy4) nb++;
      if (valid4) nv++;
      @(negedge clk);
    end
    check("t4_arm_cycles", nb, 15);
    check("t4_no_valid", nv, 0);
    check("t4_timeout", to4, 1);
    check("t4_busy", busy4, 0);
    check("t4_period_hold", per4, 0);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("t4_timeout_clr", to4, 0);
    check("t4_rearmed", busy4, 1);
    cyc(20);
    check("t4_timeout_again", to4, 1);

    // 6: async SIG_IN, START while busy ignored
    gen_on = 1'b0;
    use_async = 1'b1;
    async_on = 1'b1;
    cont = 1'b1;
    cyc(4);
    pulse_start();
    wait_valid(60, ok);
    check("t6_valid_seen", ok, 1);
    check("t6_period_rng", (period >= 9 && period <= 11), 1);
    check("t6_high_rng", (high_cnt >= 4 && high_cnt <= 6), 1);
    cyc(2);
    pulse_start();
    check("t6_busy_kept", busy, 1);
    for (int k = 0; k < 3; k++) begin
      wait_valid(30, ok);
      check("t6_cont_valid", ok, 1);
      check("t6_period_rng_k", (period >= 9 && period <= 11), 1);
    end
    check("t6_no_timeout", timeout, 0);
    cont = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_back_idle", ok, 1);
    async_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
